// File: rtl/alu_seq_driver.sv
// Sequences one command at a time through an external combinational ALU:
// latch operands, wait SETTLE cycles, capture the result, hold it until taken.
// Optional statistics counters are enabled with `define ALU_SEQ_STATS_EN.
module alu_seq_driver #(
    parameter int N      = 8,
    parameter int SETTLE = 1    // legal range 1..15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [2:0]   cmd_oper,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_oper,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_carry,
    input  logic         alu_overflow,
    input  logic         alu_negative,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic         busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]  stat_cmd_cnt,
    output logic [15:0]  stat_err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_cnt;
    logic [N-1:0]   r_alu_a;
    logic [N-1:0]   r_alu_b;
    logic [2:0]     r_alu_oper;
    logic [N-1:0]   r_rsp_result;
    logic [3:0]     r_rsp_flags;
    logic           r_rsp_err;
    logic           w_accept;
    logic           w_capture;
    logic           w_div0;

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_oper   = r_alu_oper;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_capture = (r_state == S_SETTLE) && (r_cnt == 4'd0);
    // DIV and MOD with a zero divisor: the ALU's answer is meaningless, so override it.
    assign w_div0    = ((r_alu_oper == 3'b010) || (r_alu_oper == 3'b011)) && (r_alu_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == 4'd0) w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 4'd0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_oper   <= 3'b000;
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= cmd_a;
                r_alu_b    <= cmd_b;
                r_alu_oper <= cmd_oper;
                r_cnt      <= CNT_INIT;
            end else if (r_state == S_SETTLE && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                if (w_div0) begin
                    r_rsp_result <= '0;
                    r_rsp_flags  <= 4'b0001;
                    r_rsp_err    <= 1'b1;
                end else begin
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= {alu_negative, alu_overflow, alu_carry, alu_zero};
                    r_rsp_err    <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_stat_cmd;
    logic [15:0] r_stat_err;

    // Free-running counters; natural 16-bit overflow gives the wrap to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cmd <= 16'd0;
            r_stat_err <= 16'd0;
        end else begin
            if (w_accept)            r_stat_cmd <= r_stat_cmd + 16'd1;
            if (w_capture && w_div0) r_stat_err <= r_stat_err + 16'd1;
        end
    end

    assign stat_cmd_cnt = r_stat_cmd;
    assign stat_err_cnt = r_stat_err;
`endif

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver with a behavioural ALU; second instance uses SETTLE=3.
module tb_alu_seq_driver;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // ALU model: {negative, overflow, carry, zero, result}
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                          v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'b001: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                          v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'b010: r = (b == 8'd0) ? 8'hFF : a / b;
            3'b011: r = (b == 8'd0) ? a : a % b;
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = ~a;
        endcase
        return {r[7], v, c, (r == 8'd0), r};
    endfunction

    // DUT 0: SETTLE=1
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, rsp_result;
    logic [2:0] cmd_oper, alu_oper;
    logic [3:0] rsp_flags;
    logic [11:0] alu0;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_cmd_cnt, stat_err_cnt;
`endif
    assign alu0 = alu_f(alu_a, alu_b, alu_oper);

    alu_seq_driver #(.N(8), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper),
        .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
        .alu_result(alu0[7:0]), .alu_zero(alu0[8]), .alu_carry(alu0[9]),
        .alu_overflow(alu0[10]), .alu_negative(alu0[11]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
`ifdef ALU_SEQ_STATS_EN
        , .stat_cmd_cnt(stat_cmd_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    // DUT 1: SETTLE=3
    logic       d1_cmd_valid, d1_cmd_ready, d1_rsp_valid, d1_rsp_ready, d1_rsp_err, d1_busy;
    logic [7:0] d1_cmd_a, d1_cmd_b, d1_alu_a, d1_alu_b, d1_rsp_result;
    logic [2:0] d1_cmd_oper, d1_alu_oper;
    logic [3:0] d1_rsp_flags;
    logic [11:0] alu1;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] d1_stat_cmd_cnt, d1_stat_err_cnt;
`endif
    assign alu1 = alu_f(d1_alu_a, d1_alu_b, d1_alu_oper);

    alu_seq_driver #(.N(8), .SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready),
        .cmd_a(d1_cmd_a), .cmd_b(d1_cmd_b), .cmd_oper(d1_cmd_oper),
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_oper(d1_alu_oper),
        .alu_result(alu1[7:0]), .alu_zero(alu1[8]), .alu_carry(alu1[9]),
        .alu_overflow(alu1[10]), .alu_negative(alu1[11]),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_result(d1_rsp_result),
        .rsp_flags(d1_rsp_flags), .rsp_err(d1_rsp_err), .busy(d1_busy)
`ifdef ALU_SEQ_STATS_EN
        , .stat_cmd_cnt(d1_stat_cmd_cnt), .stat_err_cnt(d1_stat_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call just after a negedge with dut0 idle; returns after the handshake, at a negedge.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [7:0] exp_r,
                          input logic [3:0] exp_f, input logic exp_e);
        int k;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_oper = op; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, ".oper"}, 32'(alu_oper), 32'(op));
        chk({tag, ".ready_lo"}, 32'(cmd_ready), 32'd0);
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".latency"}, 32'(k - 1), 32'd1);
        chk({tag, ".result"}, 32'(rsp_result), 32'(exp_r));
        chk({tag, ".flags"}, 32'(rsp_flags), 32'(exp_f));
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_e));
        chk({tag, ".ready_resp"}, 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".done_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    logic [7:0] hold_r;
    logic [3:0] hold_f;
    int         k;

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_oper = 3'd0; rsp_ready = 1'b0;
        d1_cmd_valid = 1'b0; d1_cmd_a = 8'd0; d1_cmd_b = 8'd0; d1_cmd_oper = 3'd0; d1_rsp_ready = 1'b1;
        #1;
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.alu_a", 32'(alu_a), 32'd0);
        chk("rst.alu_oper", 32'(alu_oper), 32'd0);
        chk("rst.rsp_result", 32'(rsp_result), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);

        // 100+50=150 (0x96): negative and signed overflow set
        run_op("add", 8'd100, 8'd50, 3'b000, 8'd150, 4'b1100, 1'b0);
        run_op("div", 8'd5, 8'd3, 3'b010, 8'd1, 4'b0000, 1'b0);
        run_op("mod", 8'd5, 8'd3, 3'b011, 8'd2, 4'b0000, 1'b0);
        run_op("div0", 8'd5, 8'd0, 3'b010, 8'd0, 4'b0001, 1'b1);
        run_op("or", 8'h0F, 8'hF0, 3'b101, 8'hFF, 4'b1000, 1'b0);
        run_op("xor", 8'h55, 8'h55, 3'b110, 8'h00, 4'b0001, 1'b0);
        run_op("not", 8'h0F, 8'h00, 3'b111, 8'hF0, 4'b1000, 1'b0);
        run_op("mod0", 8'd7, 8'd0, 3'b011, 8'd0, 4'b0001, 1'b1);

        // SUB 4-5 with response back-pressured for 5 cycles
        cmd_valid = 1'b1; cmd_a = 8'd4; cmd_b = 8'd5; cmd_oper = 3'b001; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("sub.result", 32'(rsp_result), 32'hFF);
        chk("sub.flags", 32'(rsp_flags), 32'(4'b1010));
        hold_r = rsp_result;
        hold_f = rsp_flags;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_a = 8'd9; cmd_b = 8'd9; cmd_oper = 3'b100;
            end
            if (i == 3) cmd_valid = 1'b0;
            @(negedge clk);
            chk("sub.hold_valid", 32'(rsp_valid), 32'd1);
            chk("sub.hold_result", 32'(rsp_result), 32'(hold_r));
            chk("sub.hold_flags", 32'(rsp_flags), 32'(hold_f));
            chk("sub.ignored_a", 32'(alu_a), 32'd4);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("sub.taken", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("sub.single_rsp", 32'(rsp_valid), 32'd0);
        chk("sub.idle", 32'(cmd_ready), 32'd1);

`ifdef ALU_SEQ_STATS_EN
        chk("stat.cmd", 32'(stat_cmd_cnt), 32'd9);
        chk("stat.err", 32'(stat_err_cnt), 32'd2);
`endif

        // SETTLE=3 instance: response appears after exactly 3 edges
        d1_cmd_valid = 1'b1; d1_cmd_a = 8'b1010_1111; d1_cmd_b = 8'b1111_0000; d1_cmd_oper = 3'b100;
        @(negedge clk);
        d1_cmd_valid = 1'b0;
        chk("s3.edge1", 32'(d1_rsp_valid), 32'd0);
        @(negedge clk);
        chk("s3.edge2", 32'(d1_rsp_valid), 32'd0);
        @(negedge clk);
        chk("s3.edge3", 32'(d1_rsp_valid), 32'd0);
        @(negedge clk);
        chk("s3.edge4_valid", 32'(d1_rsp_valid), 32'd1);
        chk("s3.result", 32'(d1_rsp_result), 32'(8'b1010_0000));
        @(negedge clk);
        chk("s3.done", 32'(d1_rsp_valid), 32'd0);

        // Reset pulse while dut0 is settling
        cmd_valid = 1'b1; cmd_a = 8'd3; cmd_b = 8'd3; cmd_oper = 3'b000; rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        chk("abort.busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort.rsp_result", 32'(rsp_result), 32'd0);
        chk("abort.rsp_flags", 32'(rsp_flags), 32'd0);
        chk("abort.alu_a", 32'(alu_a), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
`ifdef ALU_SEQ_STATS_EN
        chk("abort.stat_cmd", 32'(stat_cmd_cnt), 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort.no_rsp1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("abort.no_rsp2", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
